// File: rtl/mac_sequencer_pkg.sv
// Shared types and constants for the MAC operand sequencer.
package mac_pkg;

    typedef enum logic [1:0] {
        LAYER_CONV1 = 2'b00,
        LAYER_CONV2 = 2'b01,
        LAYER_FC    = 2'b10,
        LAYER_RSVD  = 2'b11
    } layer_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_WRITE = 2'd3
    } state_e;

    localparam int TAPS_CONV    = 25;
    localparam int TAPS_FC      = 192;
    localparam int FRAC_BITS    = 8;
    localparam int WAIT_TIMEOUT = 64;

    function automatic logic [7:0] taps_of(layer_e l);
        return (l == LAYER_FC) ? 8'(TAPS_FC) : 8'(TAPS_CONV);
    endfunction

endpackage

// File: rtl/mac_sequencer_if.sv
// Activation/weight memory read port driven by the sequencer.
interface mac_sequencer_if #(parameter int AW = 10);
    logic                 act_rd;
    logic                 wgt_rd;
    logic [AW-1:0]        act_addr;
    logic [AW-1:0]        wgt_addr;
    logic signed [15:0]   act_data;
    logic signed [15:0]   wgt_data;

    modport master (output act_rd, wgt_rd, act_addr, wgt_addr,
                    input  act_data, wgt_data);
    modport slave  (input  act_rd, wgt_rd, act_addr, wgt_addr,
                    output act_data, wgt_data);
endinterface

// File: rtl/mac_sequencer_relu_sat.sv
// Accumulator post-processing: ReLU, drop fractional bits, saturate to int16.
module relu_sat
    import mac_pkg::*;
(
    input  logic signed [31:0] acc,
    output logic signed [15:0] res
);
    logic signed [31:0] shr;

    always_comb begin
        shr = acc >>> FRAC_BITS;
        if (acc[31])
            res = '0;
        else if (shr > 32'sd32767)
            res = 16'sh7FFF;
        else
            res = shr[15:0];
    end
endmodule

// File: rtl/mac_sequencer.sv
// Sequences im2col/FC operand reads into an external MAC and writes back
// the post-processed accumulation for each output of a job.
module mac_sequencer
    import mac_pkg::*;
#(
    parameter int AW = 10
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [1:0]          layer,
    input  logic [7:0]          num_outputs,
    input  logic [AW-1:0]       act_base,
    input  logic [AW-1:0]       wgt_base,
    input  logic [AW-1:0]       out_base,
    mac_sequencer_if.master     mem,
    output logic signed [15:0]  A,
    output logic signed [15:0]  B,
    output logic                op_valid,
    output logic                op_last,
    input  logic signed [31:0]  acc_in,
    input  logic                acc_valid,
    output logic                out_we,
    output logic [AW-1:0]       out_addr,
    output logic signed [15:0]  out_data,
    output logic                busy,
    output logic                done,
    output logic                err
);
    state_e             state, nxt;
    layer_e             layer_q;
    logic [7:0]         num_q, n_q, k_q, taps;
    logic [AW-1:0]      ab_q, wb_q, ob_q, row_q, k_ext;
    logic [5:0]         tmr_q;
    logic signed [31:0] acc_q;
    logic signed [15:0] post_res;
    logic               op_valid_q, op_last_q;
    logic               start_ok, last_tap, tmo, n_more, rd, is_fc;

    relu_sat u_post (.acc(acc_q), .res(post_res));

    assign taps     = taps_of(layer_q);
    assign last_tap = (k_q == taps - 8'd1);
    assign start_ok = start && (layer != 2'b11) && (num_outputs != 8'd0);
    assign tmo      = (tmr_q == 6'(WAIT_TIMEOUT - 1));
    assign n_more   = ({1'b0, n_q} + 9'd1) < {1'b0, num_q};
    assign is_fc    = (layer_q == LAYER_FC);
    assign k_ext    = AW'(k_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:  if (start_ok) nxt = S_ISSUE;
            S_ISSUE: if (last_tap) nxt = S_WAIT;
            S_WAIT:  if (acc_valid) nxt = S_WRITE;
                     else if (tmo) nxt = S_IDLE;
            S_WRITE: nxt = n_more ? S_ISSUE : S_IDLE;
            default: nxt = S_IDLE;
        endcase
    end

    // Read addresses and write-back are decoded straight from state so the
    // first rd appears the cycle after start is accepted.
    always_comb begin
        rd            = (state == S_ISSUE);
        mem.act_rd    = rd;
        mem.wgt_rd    = rd;
        mem.act_addr  = rd ? ab_q + (is_fc ? k_ext : row_q + k_ext) : '0;
        mem.wgt_addr  = rd ? wb_q + (is_fc ? row_q + k_ext : k_ext) : '0;
        out_we        = (state == S_WRITE);
        out_addr      = out_we ? ob_q + AW'(n_q) : '0;
        out_data      = out_we ? post_res : '0;
        done          = out_we && !n_more;
        busy          = (state != S_IDLE);
        err           = reset && (((state == S_IDLE) && start && !start_ok) ||
                                  ((state == S_WAIT) && !acc_valid && tmo));
        op_valid      = op_valid_q;
        op_last       = op_last_q;
        A             = op_valid_q ? mem.act_data : '0;
        B             = op_valid_q ? mem.wgt_data : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            layer_q    <= LAYER_CONV1;
            num_q      <= '0;
            ab_q       <= '0;
            wb_q       <= '0;
            ob_q       <= '0;
            n_q        <= '0;
            k_q        <= '0;
            row_q      <= '0;
            tmr_q      <= '0;
            acc_q      <= '0;
            op_valid_q <= 1'b0;
            op_last_q  <= 1'b0;
        end else begin
            op_valid_q <= rd;
            op_last_q  <= rd && last_tap;
            case (state)
                S_IDLE: if (start_ok) begin
                    layer_q <= layer_e'(layer);
                    num_q   <= num_outputs;
                    ab_q    <= act_base;
                    wb_q    <= wgt_base;
                    ob_q    <= out_base;
                    n_q     <= '0;
                    k_q     <= '0;
                    row_q   <= '0;
                end
                S_ISSUE: begin
                    k_q   <= last_tap ? 8'd0 : k_q + 8'd1;
                    tmr_q <= '0;
                end
                S_WAIT: begin
                    tmr_q <= tmr_q + 6'd1;
                    if (acc_valid) acc_q <= acc_in;
                end
                S_WRITE: if (n_more) begin
                    n_q   <= n_q + 8'd1;
                    row_q <= row_q + AW'(taps);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mac_sequencer.sv
// Randomized scoreboard bench for mac_sequencer with a memory and MAC model.
module tb_mac_sequencer;
    import mac_pkg::*;
    localparam int AW = 10;
    localparam int MSZ = 1 << AW;

    logic clk = 0, reset = 0, start = 0;
    logic [1:0] layer = 0;
    logic [7:0] num_outputs = 0;
    logic [AW-1:0] act_base = 0, wgt_base = 0, out_base = 0;
    logic signed [15:0] A, B, out_data;
    logic op_valid, op_last, out_we, busy, done, err;
    logic signed [31:0] acc_in = 0;
    logic acc_valid = 0;
    logic [AW-1:0] out_addr;

    mac_sequencer_if #(.AW(AW)) mem ();

    mac_sequencer #(.AW(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .layer(layer),
        .num_outputs(num_outputs), .act_base(act_base), .wgt_base(wgt_base),
        .out_base(out_base), .mem(mem), .A(A), .B(B), .op_valid(op_valid),
        .op_last(op_last), .acc_in(acc_in), .acc_valid(acc_valid),
        .out_we(out_we), .out_addr(out_addr), .out_data(out_data),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct { int a; int w; } rd_t;
    typedef struct { int a; int b; bit last; } op_t;
    typedef struct { int addr; int data; } wr_t;
    typedef struct { int dly; int acc; } rsp_t;

    rd_t  exp_rd[$];
    op_t  exp_op[$];
    wr_t  exp_wr[$];
    rsp_t rsp_q[$];
    int   force_acc[$];
    int   force_dly[$];

    logic signed [15:0] act_mem [MSZ];
    logic signed [15:0] wgt_mem [MSZ];

    int checks = 0, errors = 0;
    int n_done = 0, n_err = 0, n_wr = 0;
    bit spur = 0;

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int post(int acc);
        if (acc < 0) return 0;
        if (acc / 256 > 32767) return 32767;
        return acc / 256;
    endfunction

    function automatic int rand_acc();
        case ($urandom_range(0, 3))
            0: return -int'($urandom_range(1, 1000000));
            1: return int'($urandom_range(0, 32767 * 256 + 255));
            2: return int'($urandom_range(8388608, 1073741824));
            default: return int'($urandom);
        endcase
    endfunction

    // memory: read data valid the cycle after rd
    always @(posedge clk) begin
        mem.act_data <= mem.act_rd ? act_mem[mem.act_addr] : 16'sd0;
        mem.wgt_data <= mem.wgt_rd ? wgt_mem[mem.wgt_addr] : 16'sd0;
    end

    // MAC model: returns acc dly cycles into WAIT, or never for dly < 0
    int rcnt = -1, racc = 0;
    rsp_t rs;
    always begin
        @(posedge clk); #1;
        acc_valid = 0;
        acc_in = int'($urandom);
        if (!reset) rcnt = -1;
        else begin
            if (op_valid && op_last && rsp_q.size() > 0) begin
                rs = rsp_q.pop_front();
                rcnt = rs.dly;
                racc = rs.acc;
            end
            if (rcnt == 0) begin
                acc_valid = 1;
                acc_in = racc;
                rcnt = -1;
            end else if (rcnt > 0) rcnt--;
            else if (spur && mem.act_rd) acc_valid = 1;
        end
    end

    rd_t er; op_t eo; wr_t ew;
    always @(negedge clk) if (reset) begin
        if (done) n_done++;
        if (err) n_err++;
        if (mem.act_rd || mem.wgt_rd) begin
            check("rd_expected", int'(exp_rd.size() > 0), 1);
            if (exp_rd.size() > 0) begin
                er = exp_rd.pop_front();
                check("act_addr", int'(mem.act_addr), er.a);
                check("wgt_addr", int'(mem.wgt_addr), er.w);
                check("rd_pair", int'({mem.act_rd, mem.wgt_rd}), 3);
            end
        end
        if (op_valid) begin
            check("op_expected", int'(exp_op.size() > 0), 1);
            if (exp_op.size() > 0) begin
                eo = exp_op.pop_front();
                check("op_A", int'(A), eo.a);
                check("op_B", int'(B), eo.b);
                check("op_last", int'(op_last), int'(eo.last));
            end
        end
        if (out_we) begin
            n_wr++;
            check("wr_expected", int'(exp_wr.size() > 0), 1);
            if (exp_wr.size() > 0) begin
                ew = exp_wr.pop_front();
                check("out_addr", int'(out_addr), ew.addr);
                check("out_data", int'(out_data), ew.data);
            end
        end
    end

    task automatic plan_job(int lay, int nout, int ab, int wb, int ob, int tmo_idx, output int nw);
        int taps, a, w, acc, dly;
        taps = (lay == 2) ? TAPS_FC : TAPS_CONV;
        nw = 0;
        for (int n = 0; n < nout; n++) begin
            for (int k = 0; k < taps; k++) begin
                a = ((lay == 2) ? ab + k : ab + n * taps + k) % MSZ;
                w = ((lay == 2) ? wb + n * taps + k : wb + k) % MSZ;
                exp_rd.push_back('{a, w});
                exp_op.push_back('{int'(act_mem[a]), int'(wgt_mem[w]), k == taps - 1});
            end
            if (n == tmo_idx) begin
                rsp_q.push_back('{-1, 0});
                break;
            end
            acc = (force_acc.size() > 0) ? force_acc.pop_front() : rand_acc();
            dly = (force_dly.size() > 0) ? force_dly.pop_front() : int'($urandom_range(0, 63));
            rsp_q.push_back('{dly, acc});
            exp_wr.push_back('{(ob + n) % MSZ, post(acc)});
            nw++;
        end
    endtask

    task automatic run_job(int lay, int nout, int ab, int wb, int ob, int tmo_idx,
                           bit sp, bit sbusy, bit from_reset);
        int nw, d0, e0, w0, cyc, bound;
        plan_job(lay, nout, ab, wb, ob, tmo_idx, nw);
        d0 = n_done; e0 = n_err; w0 = n_wr;
        spur = sp;
        if (from_reset) @(negedge clk);
        else begin @(posedge clk); #1; end
        layer = 2'(lay); num_outputs = 8'(nout);
        act_base = AW'(ab); wgt_base = AW'(wb); out_base = AW'(ob);
        start = 1;
        if (from_reset) reset = 1;
        @(posedge clk); #1;
        start = 0;
        check("first_rd_latency", int'(mem.act_rd), 1);
        check("busy_on_start", int'(busy), 1);
        bound = nout * ((lay == 2 ? TAPS_FC : TAPS_CONV) + 70) + 20;
        cyc = 0;
        while (busy && cyc < bound) begin
            @(negedge clk);
            cyc++;
            start = sbusy && (cyc == 5);
            if (start) begin
                layer = (lay == 2) ? 2'd0 : 2'd2;
                num_outputs = 8'd9;
                act_base = ~AW'(ab); wgt_base = ~AW'(wb); out_base = ~AW'(ob);
            end
        end
        start = 0;
        @(negedge clk); #1;
        spur = 0;
        check("job_end_busy", int'(busy), 0);
        check("done_count", n_done - d0, (tmo_idx < 0) ? 1 : 0);
        check("err_count", n_err - e0, (tmo_idx < 0) ? 0 : 1);
        check("write_count", n_wr - w0, nw);
        check("rd_left", exp_rd.size(), 0);
        check("op_left", exp_op.size(), 0);
        check("wr_left", exp_wr.size(), 0);
        check("rsp_left", rsp_q.size(), 0);
    endtask

    task automatic err_job(int lay, int nout);
        int e0;
        e0 = n_err;
        @(posedge clk); #1;
        layer = 2'(lay); num_outputs = 8'(nout); start = 1;
        @(posedge clk); #1;
        start = 0;
        check("err_busy", int'(busy), 0);
        check("err_rd", int'(mem.act_rd), 0);
        @(negedge clk);
        check("err_pulse", n_err - e0, 1);
    endtask

    initial begin
        int nw, rdc;
        for (int i = 0; i < MSZ; i++) begin
            act_mem[i] = 16'($urandom);
            wgt_mem[i] = 16'($urandom);
        end
        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_outs", int'({mem.act_rd, mem.wgt_rd, op_valid, out_we, done, err} != 0), 0);
        reset = 1;
        repeat (3) @(negedge clk);
        check("idle_busy", int'(busy), 0);

        force_acc = '{32'h00012345};
        run_job(0, 1, 'h100, 'h000, 'h050, -1, 0, 0, 0);
        force_acc = '{32'h01000000, -5};
        force_dly = '{63, 0};
        run_job(2, 2, 'h020, 'h000, 'h300, -1, 0, 0, 0);
        err_job(3, 5);
        err_job(0, 0);
        run_job(1, 2, 'h040, 'h080, 'h010, 0, 0, 0, 0);
        run_job(0, 3, 'h123, 'h3F8, 'h3FE, -1, 1, 1, 0);
        run_job(1, 2, 'h3F0, 'h3F0, 'h3FF, -1, 0, 0, 0);

        // abort mid-ISSUE
        plan_job(0, 2, 'h200, 'h010, 'h000, -1, nw);
        @(posedge clk); #1;
        layer = 0; num_outputs = 2; act_base = 'h200; wgt_base = 'h010; out_base = 0;
        start = 1;
        @(posedge clk); #1;
        start = 0;
        repeat (10) @(negedge clk);
        #2 reset = 0;
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_outs", int'({mem.act_rd, mem.wgt_rd, op_valid, op_last, out_we, done, err} != 0), 0);
        check("abort_data", int'({A, B, mem.act_addr, mem.wgt_addr, out_addr, out_data} != 0), 0);
        exp_rd.delete(); exp_op.delete(); exp_wr.delete(); rsp_q.delete();
        repeat (3) @(negedge clk);
        reset = 1;
        rdc = 0;
        repeat (8) begin
            @(negedge clk);
            if (mem.act_rd) rdc++;
        end
        check("idle_no_rd", rdc, 0);
        reset = 0;
        repeat (2) @(negedge clk);
        run_job(0, 1, 'h00A, 'h00B, 'h00C, -1, 0, 0, 1);

        for (int j = 0; j < 6; j++) begin
            int lay;
            lay = int'($urandom_range(0, 2));
            run_job(lay, int'($urandom_range(1, 3)), int'($urandom_range(0, MSZ - 1)),
                    int'($urandom_range(0, MSZ - 1)), int'($urandom_range(0, MSZ - 1)),
                    -1, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mac_sequencer.md
MAC_SEQUENCER -- requirements
Module: mac_sequencer

Interface
REQ-001 SHALL have parameter AW, default 10, memory address width.
REQ-002 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-004 SHALL have ports start  in  1  (job request pulse) and layer  in  2  (00 conv1, 01 conv2, 10 FC, 11 reserved).
REQ-005 SHALL have port num_outputs  in  8  (outputs per job, 1..255).
REQ-006 SHALL have ports act_base, wgt_base, out_base  in  AW each  (job base addresses).
REQ-007 SHALL have ports act_rd, wgt_rd  out  1 and act_addr, wgt_addr  out  AW  (memory read requests).
REQ-008 SHALL have ports act_data, wgt_data  in  16 signed  (read data, valid 1 cycle after rd).
REQ-009 SHALL have ports A, B  out  16 signed, op_valid  out  1 and op_last  out  1  (operand stream to MAC).
REQ-010 SHALL have ports acc_in  in  32 signed and acc_valid  in  1  (accumulated result from MAC).
REQ-011 SHALL have ports out_we  out  1, out_addr  out  AW and out_data  out  16 signed  (result write).
REQ-012 SHALL have ports busy, done, err  out  1 each  (status; done and err are 1-cycle pulses).

Function
REQ-013 SHALL use TAPS = 25 for layers 00/01 and TAPS = 192 for layer 10.
REQ-014 SHALL implement FSM states IDLE, ISSUE, WAIT, WRITE.
REQ-015 IDLE SHALL go to ISSUE on start=1 when layer!=11 and num_outputs!=0; otherwise start SHALL pulse err and stay in IDLE.
REQ-016 SHALL latch layer, num_outputs and all bases on an accepted start; start while busy SHALL be ignored.
REQ-017 ISSUE SHALL assert act_rd and wgt_rd every cycle for taps k = 0..TAPS-1 of output n, one tap per cycle, no bubbles.
REQ-018 Conv addressing SHALL be act_addr = act_base + n*TAPS + k and wgt_addr = wgt_base + k (im2col patches, shared kernel).
REQ-019 FC addressing SHALL be act_addr = act_base + k and wgt_addr = wgt_base + n*TAPS + k.
REQ-020 Address arithmetic SHALL wrap modulo 2^AW.
REQ-021 A=act_data and B=wgt_data SHALL be driven with op_valid=1 exactly 1 cycle after the corresponding rd.
REQ-022 op_last SHALL be 1 only with the tap k=TAPS-1 operand.
REQ-023 After the last rd, the FSM SHALL enter WAIT.
REQ-024 acc_valid SHALL be honoured only in WAIT; it SHALL be ignored in other states.
REQ-025 In WAIT, acc_valid=1 SHALL capture acc_in and move to WRITE.
REQ-026 If acc_valid has not arrived 64 cycles after entering WAIT, the block SHALL pulse err and return to IDLE with no write.
REQ-027 WRITE SHALL assert out_we for 1 cycle with out_addr = out_base + n and out_data = post(acc).
REQ-028 post(acc) SHALL be: acc<0 gives 0; otherwise acc>>>8, saturated to 32767.
REQ-029 After WRITE, the FSM SHALL go to ISSUE with n+1 when n+1 < num_outputs; otherwise it SHALL pulse done and go to IDLE.
REQ-030 busy SHALL be 1 in every state except IDLE.
REQ-031 Latency from accepted start to first rd SHALL be 1 cycle.
REQ-032 Per output, latency SHALL be TAPS + (WAIT cycles) + 1 cycles.

Reset
REQ-033 reset=0 SHALL asynchronously force IDLE and zero n, k, the timeout counter and all outputs (A, B, addresses, out_data, all strobes), including mid-job.
REQ-034 After reset release, the block SHALL accept start on the first clock edge.

Structure
REQ-035 Shared package mac_pkg SHALL hold the layer enum, TAPS_CONV=25, TAPS_FC=192, FRAC_BITS=8, WAIT_TIMEOUT=64 and the FSM state typedef.
REQ-036 Post-processing SHALL be a combinational sub-module relu_sat (32-bit in, 16-bit out).

Verification
REQ-037 Reset and idle: hold reset=0 mid-ISSUE -> all outputs 0 and busy=0 immediately; no rd after release until start.
REQ-038 Conv1 single output: layer=00, num_outputs=1, act_base=0x100, wgt_base=0x000 -> 25 rd pairs at act 0x100..0x118 and wgt 0x000..0x018; op_last on the 25th operand; acc_in=0x00012345 -> out_data=291 at out_base, then done.
REQ-039 FC two outputs: layer=10, num_outputs=2, wgt_base=0 -> second output wgt_addr starts at 192; acc_in=0x01000000 -> out_data=0x7FFF; acc_in=-5 -> out_data=0.
REQ-040 Errors: layer=11 or num_outputs=0 -> err pulse, busy stays 0; no acc_valid for 64 cycles in WAIT -> err, IDLE, no out_we.
REQ-041 Spurious inputs: acc_valid during ISSUE and start while busy -> no effect on outputs, write count or addresses.
REQ-042 Wrap-around: AW=10, act_base=0x3F0, conv -> act_addr wraps 0x3FF -> 0x000 with no error.
